or1200_dcpu_arb: RTL

//  Two-requester arbiter merging the CPU's dual data ports (dcpu_*_o / dcpu_*_o2)

---
 rtl/or1200_dcpu_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/or1200_dcpu_arb.sv
// Two-requester arbiter merging the CPU's dual data ports onto one
// downstream cache/memory port. One transaction is outstanding at a time.
// Port 0 carries the older instruction, so fixed priority keeps program order.
// A watchdog terminates hung accesses with an error.
//
// Handshake: a requester raises pN_cycstb_i with stable adr/we/sel/tag/dat and
// holds it until it sees pN_ack_o, pN_rty_o or pN_err_o in the same cycle; the
// following cycle it may drop the request or keep it high for a new transaction.
// Downstream sees m_cycstb_o held with stable m_* until m_ack_i/m_rty_i/m_err_i,
// after which m_cycstb_o falls (or carries the next winner) on the next edge.
module or1200_dcpu_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TW      = 4,
  parameter int RR      = 0,
  parameter int TOW     = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] p0_adr_i,
  input  logic          p0_cycstb_i,
  input  logic          p0_we_i,
  input  logic [3:0]    p0_sel_i,
  input  logic [TW-1:0] p0_tag_i,
  input  logic [DW-1:0] p0_dat_i,
  output logic [DW-1:0] p0_dat_o,
  output logic          p0_ack_o,
  output logic          p0_rty_o,
  output logic          p0_err_o,
  output logic [TW-1:0] p0_tag_o,
  input  logic [AW-1:0] p1_adr_i,
  input  logic          p1_cycstb_i,
  input  logic          p1_we_i,
  input  logic [3:0]    p1_sel_i,
  input  logic [TW-1:0] p1_tag_i,
  input  logic [DW-1:0] p1_dat_i,
  output logic [DW-1:0] p1_dat_o,
  output logic          p1_ack_o,
  output logic          p1_rty_o,
  output logic          p1_err_o,
  output logic [TW-1:0] p1_tag_o,
  output logic [AW-1:0] m_adr_o,
  output logic          m_cycstb_o,
  output logic          m_we_o,
  output logic [3:0]    m_sel_o,
  output logic [TW-1:0] m_tag_o,
  output logic [DW-1:0] m_dat_o,
  input  logic [DW-1:0] m_dat_i,
  input  logic          m_ack_i,
  input  logic          m_rty_i,
  input  logic          m_err_i,
  input  logic [TW-1:0] m_tag_i,
  output logic [1:0]    grant_o,
  output logic          timeout_o,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam int          TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TOW-1:0] TO_CMP = TOW'(TO_LAST);

  state_t         state_q, state_d;
  logic           last_grant_q;
  logic [TOW-1:0] cnt_q;
  logic           resp, to_fire, busy, any_req;
  logic           arb_port, load, load_port;

  assign resp    = m_ack_i | m_rty_i | m_err_i;
  assign busy    = (state_q != IDLE);
  assign any_req = p0_cycstb_i | p1_cycstb_i;
  // The watchdog fires on the TIMEOUT-th busy cycle (counter starts at 0).
  assign to_fire = TO_EN & busy & ~resp & (cnt_q == TO_CMP);

  // Pick the winner among current requests (tie: port 0, or the port not last granted).
  always_comb begin
    arb_port = p1_cycstb_i;
    if (p0_cycstb_i && p1_cycstb_i)
      arb_port = (RR != 0) ? ~last_grant_q : 1'b0;
  end

  // Next-state logic; a direct handover to the other port skips the idle bubble.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_port = arb_port;
    case (state_q)
      IDLE: if (any_req) load = 1'b1;
      GNT0: begin
        if (resp) begin
          if (p1_cycstb_i) begin load = 1'b1; load_port = 1'b1; end
          else state_d = IDLE;
        end else if (to_fire) state_d = IDLE;
        else if (!p0_cycstb_i) state_d = DRAIN;
      end
      GNT1: begin
        if (resp) begin
          if (p0_cycstb_i) begin load = 1'b1; load_port = 1'b0; end
          else state_d = IDLE;
        end else if (to_fire) state_d = IDLE;
        else if (!p1_cycstb_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (resp) begin
          if (any_req) load = 1'b1;
          else state_d = IDLE;
        end else if (to_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) state_d = load_port ? GNT1 : GNT0;
  end

  // State, last-grant memory and the registered downstream request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      m_cycstb_o   <= 1'b0;
      m_adr_o      <= '0;
      m_we_o       <= 1'b0;
      m_sel_o      <= '0;
      m_tag_o      <= '0;
      m_dat_o      <= '0;
    end else begin
      state_q    <= state_d;
      m_cycstb_o <= (state_d != IDLE);
      if (load) begin
        last_grant_q <= load_port;
        m_adr_o      <= load_port ? p1_adr_i : p0_adr_i;
        m_we_o       <= load_port ? p1_we_i  : p0_we_i;
        m_sel_o      <= load_port ? p1_sel_i : p0_sel_i;
        m_tag_o      <= load_port ? p1_tag_i : p0_tag_i;
        m_dat_o      <= load_port ? p1_dat_i : p0_dat_i;
      end
    end
  end

  // Watchdog counter: clears on every state change, saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (state_d != state_q) cnt_q <= '0;
    else if (busy && !resp && (cnt_q != {TOW{1'b1}})) cnt_q <= cnt_q + 1'b1;
  end

  // Responses route combinationally to the granted port only; err beats ack.
  logic g0, g1;
  assign g0 = (state_q == GNT0);
  assign g1 = (state_q == GNT1);

  assign p0_ack_o  = g0 & m_ack_i & ~m_err_i;
  assign p0_rty_o  = g0 & m_rty_i & ~m_err_i;
  assign p0_err_o  = g0 & (m_err_i | to_fire);
  assign p0_dat_o  = g0 ? m_dat_i : '0;
  assign p0_tag_o  = g0 ? m_tag_i : '0;
  assign p1_ack_o  = g1 & m_ack_i & ~m_err_i;
  assign p1_rty_o  = g1 & m_rty_i & ~m_err_i;
  assign p1_err_o  = g1 & (m_err_i | to_fire);
  assign p1_dat_o  = g1 ? m_dat_i : '0;
  assign p1_tag_o  = g1 ? m_tag_i : '0;
  assign grant_o   = {g1, g0};
  assign timeout_o = to_fire;
  assign fsm_state = state_q;

endmodule
